hvsync_timing_generator: RTL and testbench



---
 rtl/video_timing_pkg.sv | 45 ++++
 rtl/hvsync_timing_generator_if.sv | 36 +++
 rtl/hvsync_timing_generator.sv | 140 ++++++++++++++
 tb/tb_hvsync_timing_generator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared raster timing constants for the video path. The eight base timing
// values are the defaults of hvsync_timing_generator; the derived START/END/MAX
// positions let the video driver and the timing generator agree on one raster.
// Also holds the beam counter width and a small window-compare helper.
// -----------------------------------------------------------------------------
package video_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_DISPLAY = 256;
  localparam int H_BACK    = 23;
  localparam int H_FRONT   = 7;
  localparam int H_SYNC    = 23;

  // Vertical timing, in lines
  localparam int V_DISPLAY = 240;
  localparam int V_TOP     = 5;
  localparam int V_BOTTOM  = 14;
  localparam int V_SYNC    = 3;

  // Asserted levels of the sync outputs
  localparam logic HSYNC_ACTIVE = 1'b1;
  localparam logic VSYNC_ACTIVE = 1'b1;

  // Derived raster positions (sync sits after the front/bottom border)
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

  // Beam counter width and the largest position it can hold
  localparam int CNT_W     = 9;
  localparam int CNT_LIMIT = (32'sd1 <<< CNT_W) - 32'sd1;

  // True when val lies in the inclusive window [lo, hi]
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/hvsync_timing_generator_if.sv
// -----------------------------------------------------------------------------
// hvsync_timing_generator_if
// Raster timing bundle produced by hvsync_timing_generator.
//   hsync       registered horizontal sync
//   vsync       registered vertical sync (also the CPU frame tick)
//   display_on  high inside the visible area
//   hpos/vpos   beam counters
// master: the timing generator (drives everything)
// slave : consumers (video driver, CPU tick, RGB gating)
// -----------------------------------------------------------------------------
interface hvsync_timing_generator_if;
  import video_timing_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );

endinterface

// File: rtl/hvsync_timing_generator.sv
// -----------------------------------------------------------------------------
// hvsync_timing_generator
// Raster timing generator: horizontal/vertical beam counters, registered sync
// pulses and a combinational display-active flag, all from one pixel clock.
// Ports:
//   clk    in   pixel clock, rising edge
//   reset  in   asynchronous reset, active-low
//   o_vid  master modport of hvsync_timing_generator_if
//          (hsync, vsync, display_on, hpos, vpos)
// The sync registers sample the current counter value, so each pulse appears
// one clock after the counter enters the sync window.
// -----------------------------------------------------------------------------
module hvsync_timing_generator #(
  parameter int   H_DISPLAY    = video_timing_pkg::H_DISPLAY,
  parameter int   H_BACK       = video_timing_pkg::H_BACK,
  parameter int   H_FRONT      = video_timing_pkg::H_FRONT,
  parameter int   H_SYNC       = video_timing_pkg::H_SYNC,
  parameter int   V_DISPLAY    = video_timing_pkg::V_DISPLAY,
  parameter int   V_TOP        = video_timing_pkg::V_TOP,
  parameter int   V_BOTTOM     = video_timing_pkg::V_BOTTOM,
  parameter int   V_SYNC       = video_timing_pkg::V_SYNC,
  parameter logic HSYNC_ACTIVE = video_timing_pkg::HSYNC_ACTIVE,
  parameter logic VSYNC_ACTIVE = video_timing_pkg::VSYNC_ACTIVE
) (
  input  logic                      clk,
  input  logic                      reset,
  hvsync_timing_generator_if.master o_vid
);
  import video_timing_pkg::*;

  // Raster positions for this instance's parameter set
  localparam int H_SYNC_START_I = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END_I   = H_SYNC_START_I + H_SYNC - 1;
  localparam int H_MAX_I        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int V_SYNC_START_I = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END_I   = V_SYNC_START_I + V_SYNC - 1;
  localparam int V_MAX_I        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;

  // Any raster position that does not fit the counters is rejected here
  if ((H_MAX_I > CNT_LIMIT) || (V_MAX_I > CNT_LIMIT)) begin : g_range_error
    $error("hvsync_timing_generator: timing sums exceed the 9-bit counter range");
  end

  localparam logic [CNT_W-1:0] L_H_DISPLAY    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] L_H_SYNC_START = CNT_W'(H_SYNC_START_I);
  localparam logic [CNT_W-1:0] L_H_SYNC_END   = CNT_W'(H_SYNC_END_I);
  localparam logic [CNT_W-1:0] L_H_MAX        = CNT_W'(H_MAX_I);
  localparam logic [CNT_W-1:0] L_V_DISPLAY    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] L_V_SYNC_START = CNT_W'(V_SYNC_START_I);
  localparam logic [CNT_W-1:0] L_V_SYNC_END   = CNT_W'(V_SYNC_END_I);
  localparam logic [CNT_W-1:0] L_V_MAX        = CNT_W'(V_MAX_I);
  localparam logic [CNT_W-1:0] L_ZERO         = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] L_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_h_wrap;
  logic [CNT_W-1:0] w_hpos_nxt;
  logic [CNT_W-1:0] w_vpos_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_display_on;

  assign w_h_wrap = (r_hpos == L_H_MAX);

  // Horizontal counter: count up, wrap to 0 after the last clock of the line
  always_comb begin
    w_hpos_nxt = r_hpos;
    if (w_h_wrap) begin
      w_hpos_nxt = L_ZERO;
    end else begin
      w_hpos_nxt = r_hpos + L_ONE;
    end
  end

  // Vertical counter: steps only on the line-wrap clock, wraps on the same edge
  always_comb begin
    w_vpos_nxt = r_vpos;
    if (w_h_wrap) begin
      if (r_vpos == L_V_MAX) begin
        w_vpos_nxt = L_ZERO;
      end else begin
        w_vpos_nxt = r_vpos + L_ONE;
      end
    end else begin
      w_vpos_nxt = r_vpos;
    end
  end

  // Sync levels decoded from the current (not next) counter values
  always_comb begin
    w_hsync_nxt = ~HSYNC_ACTIVE;
    w_vsync_nxt = ~VSYNC_ACTIVE;
    if (in_window(r_hpos, L_H_SYNC_START, L_H_SYNC_END)) begin
      w_hsync_nxt = HSYNC_ACTIVE;
    end else begin
      w_hsync_nxt = ~HSYNC_ACTIVE;
    end
    if (in_window(r_vpos, L_V_SYNC_START, L_V_SYNC_END)) begin
      w_vsync_nxt = VSYNC_ACTIVE;
    end else begin
      w_vsync_nxt = ~VSYNC_ACTIVE;
    end
  end

  // Visible-area flag follows the counters with no register stage
  always_comb begin
    w_display_on = 1'b0;
    if ((r_hpos < L_H_DISPLAY) && (r_vpos < L_V_DISPLAY)) begin
      w_display_on = 1'b1;
    end else begin
      w_display_on = 1'b0;
    end
  end

  // Beam counters and sync registers; reset parks the beam at the origin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hpos  <= L_ZERO;
      r_vpos  <= L_ZERO;
      r_hsync <= ~HSYNC_ACTIVE;
      r_vsync <= ~VSYNC_ACTIVE;
    end else begin
      r_hpos  <= w_hpos_nxt;
      r_vpos  <= w_vpos_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
    end
  end

  assign o_vid.hpos       = r_hpos;
  assign o_vid.vpos       = r_vpos;
  assign o_vid.hsync      = r_hsync;
  assign o_vid.vsync      = r_vsync;
  assign o_vid.display_on = w_display_on;

endmodule

// File: tb/tb_hvsync_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_hvsync_timing_generator
// Drives two generators (active-high and active-low sync) through a mid-line
// reset and one full frame. Expected raster states are computed from the cycle
// index since reset release, queued on each clock edge and compared on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_hvsync_timing_generator;

  localparam int H_TOTAL = 309;
  localparam int V_TOTAL = 262;
  localparam int FRAME   = 80958;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues, packed as {hpos, vpos, hsync, vsync, display_on}
  logic [20:0] q_pos[$];
  logic [20:0] q_neg[$];

  // Frame statistics gathered from the observed outputs
  int  hs_cnt_pos, hs_first_h, hs_last_h, hs_cnt_neg;
  int  vs_cnt_pos, vs_cnt_neg, de_cnt;
  int  vs_rise_h, vs_rise_v, vs_fall_h, vs_fall_v;
  logic prev_vs;

  hvsync_timing_generator_if if_pos();
  hvsync_timing_generator_if if_neg();

  hvsync_timing_generator #(
    .HSYNC_ACTIVE(1'b1),
    .VSYNC_ACTIVE(1'b1)
  ) u_dut_pos (
    .clk   (clk),
    .reset (reset),
    .o_vid (if_pos.master)
  );

  hvsync_timing_generator #(
    .HSYNC_ACTIVE(1'b0),
    .VSYNC_ACTIVE(1'b0)
  ) u_dut_neg (
    .clk   (clk),
    .reset (reset),
    .o_vid (if_neg.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected raster state n clocks after reset release
  function automatic logic [20:0] expect_state(input int n, input logic hs_act, input logic vs_act);
    int   h, v, hp, vp;
    logic hs, vs, de;
    h  = n % H_TOTAL;
    v  = (n / H_TOTAL) % V_TOTAL;
    hs = ~hs_act;
    vs = ~vs_act;
    if (n > 0) begin
      hp = (n - 1) % H_TOTAL;
      vp = ((n - 1) / H_TOTAL) % V_TOTAL;
      if (hp >= 263 && hp <= 285) hs = hs_act;
      if (vp >= 254 && vp <= 256) vs = vs_act;
    end
    de = (h < 256) && (v < 240);
    return {h[8:0], v[8:0], hs, vs, de};
  endfunction

  function automatic logic [20:0] obs_pos();
    return {if_pos.hpos, if_pos.vpos, if_pos.hsync, if_pos.vsync, if_pos.display_on};
  endfunction

  function automatic logic [20:0] obs_neg();
    return {if_neg.hpos, if_neg.vpos, if_neg.hsync, if_neg.vsync, if_neg.display_on};
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pos"}, 32'(obs_pos()), 32'({9'd0, 9'd0, 1'b0, 1'b0, 1'b1}));
    check_eq({tag, "_neg"}, 32'(obs_neg()), 32'({9'd0, 9'd0, 1'b1, 1'b1, 1'b1}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [20:0] exp_v;

    // Power-up reset, then run into the middle of a line
    #3 reset = 1'b0;
    #20 reset = 1'b1;
    repeat (150) @(posedge clk);

    // Asynchronous reset mid-line: outputs clear before any clock edge
    #2 reset = 1'b0;
    #1 check_reset_state("rst_async");
    repeat (5) begin
      @(negedge clk);
      check_reset_state("rst_hold");
    end
    reset = 1'b1;
    #1 check_reset_state("rst_release");

    hs_cnt_pos = 0; hs_first_h = -1; hs_last_h = -1; hs_cnt_neg = 0;
    vs_cnt_pos = 0; vs_cnt_neg = 0; de_cnt = 0;
    vs_rise_h = -1; vs_rise_v = -1; vs_fall_h = -1; vs_fall_v = -1;
    prev_vs = 1'b0;

    for (int k = 1; k <= FRAME + 1; k++) begin
      @(posedge clk);
      q_pos.push_back(expect_state(k, 1'b1, 1'b1));
      q_neg.push_back(expect_state(k, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = q_pos.pop_front();
      check_eq($sformatf("cyc_pos_%0d", k), 32'(obs_pos()), 32'(exp_v));
      exp_v = q_neg.pop_front();
      check_eq($sformatf("cyc_neg_%0d", k), 32'(obs_neg()), 32'(exp_v));

      if (k == 1)   check_eq("rel_first_h", 32'(if_pos.hpos), 32'd1);
      if (k == 308) check_eq("hwrap_pre", 32'({if_pos.hpos, if_pos.vpos}), 32'({9'd308, 9'd0}));
      if (k == 309) check_eq("hwrap_post", 32'({if_pos.hpos, if_pos.vpos}), 32'({9'd0, 9'd1}));
      if (k == 239 * 309 + 255) check_eq("disp_255_239", 32'(if_pos.display_on), 32'd1);
      if (k == 256)             check_eq("disp_256_0", 32'(if_pos.display_on), 32'd0);
      if (k == 240 * 309)       check_eq("disp_0_240", 32'(if_pos.display_on), 32'd0);
      if (k == 261 * 309 + 308) check_eq("disp_308_261", 32'(if_pos.display_on), 32'd0);
      if (k == FRAME) check_eq("frame_wrap", 32'({if_pos.hpos, if_pos.vpos}), 32'd0);

      if (k <= 309) begin
        if (if_pos.hsync) begin
          hs_cnt_pos++;
          if (hs_first_h < 0) hs_first_h = int'(if_pos.hpos);
          hs_last_h = int'(if_pos.hpos);
        end
        if (!if_neg.hsync) hs_cnt_neg++;
      end

      if (k <= FRAME) begin
        if (if_pos.vsync) vs_cnt_pos++;
        if (!if_neg.vsync) vs_cnt_neg++;
        if (if_pos.display_on) de_cnt++;
        if (if_pos.vsync && !prev_vs && vs_rise_h < 0) begin
          vs_rise_h = int'(if_pos.hpos);
          vs_rise_v = int'(if_pos.vpos);
        end
        if (!if_pos.vsync && prev_vs && vs_fall_h < 0) begin
          vs_fall_h = int'(if_pos.hpos);
          vs_fall_v = int'(if_pos.vpos);
        end
        prev_vs = if_pos.vsync;
      end
    end

    check_eq("hsync_count", 32'(hs_cnt_pos), 32'd23);
    check_eq("hsync_first_h", 32'(hs_first_h), 32'd264);
    check_eq("hsync_last_h", 32'(hs_last_h), 32'd286);
    check_eq("hsync_neg_low_count", 32'(hs_cnt_neg), 32'd23);
    check_eq("vsync_count", 32'(vs_cnt_pos), 32'd927);
    check_eq("vsync_neg_low_count", 32'(vs_cnt_neg), 32'd927);
    check_eq("vsync_rise", 32'({vs_rise_v[8:0], vs_rise_h[8:0]}), 32'({9'd254, 9'd1}));
    check_eq("vsync_fall", 32'({vs_fall_v[8:0], vs_fall_h[8:0]}), 32'({9'd257, 9'd1}));
    check_eq("display_count", 32'(de_cnt), 32'd61440);
    check_eq("queue_drained", 32'(q_pos.size() + q_neg.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
